serial_out_sequencer: RTL and testbench
=======================================

# serial_out_sequencer

Launch sequencer for the 16 `serial_out` channel engines. It holds a per-channel enable and start-delay table. On one `i_go` command it issues each enabled channel's one-cycle start tick at a programmed offset from a shared timer. It then collects the channels' done ticks and reports sequence completion, or stops all running channels on abort. It sits between the packet decoder/config path and the `serial_out` instances, replacing the single broadcast start tick with a time-staggered launch.

## Interface
- `N_CH`, 16, number of channels (≤16; `i_cfg_ch` is 4 bits).
- `DLY_BIT`, 16, width of start delays and of the sequence timer.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_cfg_we` in 1: config write strobe.
- `i_cfg_ch` in 4: channel index for the write.
- `i_cfg_en` in 1: channel enable value to write.
- `i_cfg_delay` in DLY_BIT: start delay to write, in clk cycles.
- `i_go` in 1: start-sequence pulse.
- `i_abort` in 1: abort pulse.
- `i_ch_done` in N_CH: done ticks from the `serial_out` channels.
- `o_start_tick` out N_CH: one-cycle start pulse per channel.
- `o_stop` out N_CH: one-cycle stop pulse per channel.
- `o_active` out N_CH: channel launched and not yet done.
- `o_busy` out 1: high in any state other than S_IDLE.
- `o_seq_done_tick` out 1: one-cycle pulse at normal sequence completion.

## Operation
- Registers:
  - delay table: N_CH × DLY_BIT
  - enable vector
  - launched vector
  - done vector
  - timer: DLY_BIT bits
  - 2-bit state
- States and transitions:
  - S_IDLE: wait for `i_go` → S_RUN.
  - S_RUN: timer counts from 0. On the cycle where timer == delay[ch], each enabled, unlaunched channel ch gets `o_start_tick[ch]` and sets launched[ch]. Leave for S_WAIT once every enabled channel is launched.
  - S_WAIT: wait until done == enable → S_DONE.
  - S_DONE: assert `o_seq_done_tick` for one cycle → S_IDLE.
- Several channels with equal delay start in the same cycle.
- `i_ch_done[ch]` sets done[ch] only if launched[ch] is set. It is accepted in S_RUN and S_WAIT. Done ticks from unlaunched or disabled channels are ignored.
- `o_active` = launched & ~done.
- Config writes:
  - Applied only in S_IDLE; ignored when `o_busy`.
  - `i_cfg_ch` ≥ N_CH: write ignored.
  - A write in the same cycle as `i_go` is applied, and the sequence uses the new value.
- `i_go` with the enable vector all zero → S_DONE directly. No start ticks are issued.
- `i_go` while busy: ignored.
- Abort:
  - `i_abort` in S_RUN or S_WAIT: `o_stop` pulses one cycle on exactly the channels in `o_active`.
  - Unlaunched channels are never started.
  - No `o_seq_done_tick` is issued.
  - State → S_IDLE.
  - launched, done and timer are cleared.
- `i_abort` in S_IDLE or S_DONE: no effect.
- `i_abort` and `i_go` in the same cycle: abort wins; `i_go` is dropped.
- Timer never wraps: S_RUN exits by the cycle timer reaches the maximum enabled delay (≤ 2^DLY_BIT−1).
- launched, done and timer clear on entry to S_RUN.
- The delay/enable table persists across sequences.

## Timing
- Reset values:
  - state: S_IDLE
  - delay table: 0
  - enable vector: 0
  - launched / done / timer: 0
  - all outputs: 0
- Reset mid-sequence drops all state with no stop pulse. The `serial_out` instances share the reset.
- `i_go` sampled high at cycle 0 → `o_busy` = 1 from cycle 1.
- A channel with delay D has `o_start_tick` high in cycle 1 + D.
- S_RUN → S_WAIT the cycle after the last start tick.
- Last enabled done tick in cycle T → `o_seq_done_tick` high in cycle T+1 (S_DONE) → `o_busy` = 0 in cycle T+2. The next `i_go` is accepted in cycle T+2.
- Done tick arriving in S_RUN for an already-launched channel: recorded. The sequence still waits for the remaining launches.
- `i_abort` sampled at cycle A → `o_stop` pulse in cycle A+1 (from `o_active` at A) → `o_busy` = 0 in cycle A+1.
- All outputs are registered. `o_start_tick`, `o_stop` and `o_seq_done_tick` are never high for more than one consecutive cycle per event.

## Test plan
- Staggered launch:
  - Stimulus: enable ch0/ch1/ch2 with delays 0/5/5, `i_go` at cycle 0, done ticks at cycles 20/30/25.
  - Required: start ticks at cycle 1 (ch0) and cycle 6 (ch1+ch2); `o_seq_done_tick` at cycle 31; `o_busy` low at cycle 32.
- Empty table: no channels enabled, `i_go` at cycle 0 → no start ticks; `o_seq_done_tick` at cycle 1.
- Abort mid-run:
  - Stimulus: ch0 delay 2, ch3 delay 100; `i_abort` at cycle 10.
  - Required: `o_stop` = 16'h0001 at cycle 11; ch3 never started; no done tick; idle at cycle 11.
- Illegal and spurious inputs:
  - Config write while busy → table unchanged; readback is via the next sequence's start timing.
  - `i_go` while busy → ignored.
  - Done tick from a disabled channel → ignored; completion still waits on the enabled channels.
- Simultaneous `i_go` + `i_abort` in S_IDLE → stays idle, no ticks. Then `i_go` + `i_cfg_we` (ch5, en=1, delay=3) in the same cycle → ch5 start tick at cycle 4.
- Reset: `rst` high during S_WAIT → next cycle all outputs 0, state S_IDLE, table cleared; a subsequent `i_go` completes immediately.

Source files
------------

// File: rtl/serial_out_sequencer.sv
// Launch sequencer for the serial_out channel engines: staggered start ticks from a
// shared timer, done collection, sequence-complete pulse and abort with per-channel stop.
module serial_out_sequencer #(
  parameter int N_CH    = 16,
  parameter int DLY_BIT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cfg_we,
  input  logic [3:0]         i_cfg_ch,
  input  logic               i_cfg_en,
  input  logic [DLY_BIT-1:0] i_cfg_delay,
  input  logic               i_go,
  input  logic               i_abort,
  input  logic [N_CH-1:0]    i_ch_done,
  output logic [N_CH-1:0]    o_start_tick,
  output logic [N_CH-1:0]    o_stop,
  output logic [N_CH-1:0]    o_active,
  output logic               o_busy,
  output logic               o_seq_done_tick
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [4:0] N_CH_W = 5'(N_CH);

  state_t             state, state_nxt;
  logic [DLY_BIT-1:0] dly_tbl [N_CH];
  logic [DLY_BIT-1:0] timer;
  logic [N_CH-1:0]    en, launched, done;
  logic [N_CH-1:0]    en_eff, zero_eff, hit, done_nxt;
  logic               cfg_ok, go_ok, abort_ok;

  assign cfg_ok   = i_cfg_we && (state == S_IDLE) && ({1'b0, i_cfg_ch} < N_CH_W);
  assign go_ok    = i_go && !i_abort && (state == S_IDLE);
  assign abort_ok = i_abort && ((state == S_RUN) || (state == S_WAIT));

  // A config write landing with i_go must already shape the launch, so the
  // enable/zero-delay view at go time looks through the pending write.
  always_comb begin
    en_eff   = en;
    zero_eff = '0;
    hit      = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      zero_eff[ch] = (dly_tbl[ch] == '0);
      hit[ch]      = en[ch] && !launched[ch] && (dly_tbl[ch] == timer);
      if (cfg_ok && (i_cfg_ch == 4'(ch))) begin
        en_eff[ch]   = i_cfg_en;
        zero_eff[ch] = (i_cfg_delay == '0);
      end
    end
    done_nxt = done | (i_ch_done & launched);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (go_ok) state_nxt = (en_eff == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort_ok)               state_nxt = S_IDLE;
        else if (launched == en)    state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (abort_ok)               state_nxt = S_IDLE;
        else if (done_nxt == en)    state_nxt = S_DONE;
      end
      default:                      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Timer holds the cycle index since go; a match registers the tick so it
  // appears in cycle 1 + delay. Zero-delay channels are launched from the go edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < N_CH; ch++) dly_tbl[ch] <= '0;
      en              <= '0;
      launched        <= '0;
      done            <= '0;
      timer           <= '0;
      o_start_tick    <= '0;
      o_stop          <= '0;
      o_seq_done_tick <= 1'b0;
    end else begin
      o_start_tick    <= '0;
      o_stop          <= '0;
      o_seq_done_tick <= (state_nxt == S_DONE) && (state != S_DONE);
      if (cfg_ok) begin
        en[i_cfg_ch]      <= i_cfg_en;
        dly_tbl[i_cfg_ch] <= i_cfg_delay;
      end
      if (abort_ok) begin
        o_stop   <= launched & ~done;
        launched <= '0;
        done     <= '0;
        timer    <= '0;
      end else begin
        case (state)
          S_IDLE: if (go_ok) begin
            o_start_tick <= en_eff & zero_eff;
            launched     <= en_eff & zero_eff;
            done         <= '0;
            timer        <= DLY_BIT'(1);
          end
          S_RUN: begin
            o_start_tick <= hit;
            launched     <= launched | hit;
            done         <= done_nxt;
            timer        <= timer + 1'b1;
          end
          S_WAIT:  done <= done_nxt;
          default: ;
        endcase
      end
    end
  end

  assign o_active = launched & ~done;
  assign o_busy   = (state != S_IDLE);

endmodule

// File: tb/tb_serial_out_sequencer.sv
// Self-checking bench for serial_out_sequencer: directed plan steps plus randomized
// sequences compared cycle by cycle against a timing model of the launch table.
module tb_serial_out_sequencer;
  localparam int N_CH    = 16;
  localparam int DLY_BIT = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_cfg_we;
  logic [3:0]         i_cfg_ch;
  logic               i_cfg_en;
  logic [DLY_BIT-1:0] i_cfg_delay;
  logic               i_go;
  logic               i_abort;
  logic [N_CH-1:0]    i_ch_done;
  logic [N_CH-1:0]    o_start_tick;
  logic [N_CH-1:0]    o_stop;
  logic [N_CH-1:0]    o_active;
  logic               o_busy;
  logic               o_seq_done_tick;

  int checks = 0;
  int errors = 0;
  int en_m  [N_CH];
  int dly_m [N_CH];
  int dt    [N_CH];

  serial_out_sequencer #(.N_CH(N_CH), .DLY_BIT(DLY_BIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_cfg_we        (i_cfg_we),
    .i_cfg_ch        (i_cfg_ch),
    .i_cfg_en        (i_cfg_en),
    .i_cfg_delay     (i_cfg_delay),
    .i_go            (i_go),
    .i_abort         (i_abort),
    .i_ch_done       (i_ch_done),
    .o_start_tick    (o_start_tick),
    .o_stop          (o_stop),
    .o_active        (o_active),
    .o_busy          (o_busy),
    .o_seq_done_tick (o_seq_done_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_go      = 1'b0;
    i_abort   = 1'b0;
    i_cfg_we  = 1'b0;
    i_ch_done = '0;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outs(input int k, input logic [15:0] tick, input logic [15:0] stop,
                            input logic [15:0] act, input logic busy, input logic sd);
    chk("start_tick", k, 32'(o_start_tick), 32'(tick));
    chk("stop", k, 32'(o_stop), 32'(stop));
    chk("active", k, 32'(o_active), 32'(act));
    chk("busy", k, 32'(o_busy), 32'(busy));
    chk("seq_done", k, 32'(o_seq_done_tick), 32'(sd));
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < N_CH; ch++) begin
      en_m[ch]  = 0;
      dly_m[ch] = 0;
    end
  endtask

  task automatic cfg(input int ch, input bit en, input int dly);
    i_cfg_we    = 1'b1;
    i_cfg_ch    = 4'(ch);
    i_cfg_en    = en;
    i_cfg_delay = 16'(dly);
    en_m[ch]    = int'(en);
    dly_m[ch]   = dly;
    step();
    i_cfg_we = 1'b0;
  endtask

  // A channel counts as active from its launch cycle through the cycle of its done tick.
  function automatic bit act_at(input int ch, input int k);
    return (en_m[ch] != 0) && (k >= 1 + dly_m[ch]) && (k <= dt[ch]);
  endfunction

  // Issues i_go in the current cycle (cycle 0) and checks every following cycle.
  // abort_sel: -1 none, 0 random point, >0 fixed abort cycle.
  task automatic run_seq(input bit rand_dt, input int abort_sel, input bit noise, input bit busy_poke);
    int  last_launch, last_done, sd, a_cyc, a_noop, last;
    bit  any, aborted;
    logic [15:0] e_tick, e_stop, e_act;
    any = 0; last_launch = 0; last_done = 0; a_cyc = -1; a_noop = -1;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (en_m[ch] != 0) begin
        any = 1;
        if (rand_dt) dt[ch] = 2 + dly_m[ch] + int'($urandom_range(30, 0));
        if (1 + dly_m[ch] > last_launch) last_launch = 1 + dly_m[ch];
        if (dt[ch] > last_done) last_done = dt[ch];
      end
    end
    sd = any ? (((last_done > last_launch + 1) ? last_done : last_launch + 1) + 1) : 1;
    if (abort_sel > 0)                a_cyc  = abort_sel;
    else if (abort_sel == 0 && any)   a_cyc  = int'($urandom_range(sd - 1, 1));
    else if (abort_sel == 0)          a_noop = sd;
    last = (a_cyc >= 0) ? a_cyc + 2 : sd + 1;
    i_go = 1'b1;
    for (int k = 1; k <= last; k++) begin
      step();
      idle_inputs();
      aborted = (a_cyc >= 0) && (k > a_cyc);
      e_tick = '0; e_stop = '0; e_act = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (!aborted && en_m[ch] != 0 && k == 1 + dly_m[ch]) e_tick[ch] = 1'b1;
        if (!aborted) e_act[ch] = act_at(ch, k);
        if (aborted && k == a_cyc + 1) e_stop[ch] = act_at(ch, a_cyc);
      end
      check_outs(k, e_tick, e_stop, e_act, !aborted && (k <= sd), !aborted && (k == sd));
      if (k < last) begin
        for (int ch = 0; ch < N_CH; ch++) begin
          if (en_m[ch] != 0 && dt[ch] == k && !(a_cyc >= 0 && k >= a_cyc)) i_ch_done[ch] = 1'b1;
          if (noise && (en_m[ch] == 0 || k < 1 + dly_m[ch]) && $urandom_range(3, 0) == 0)
            i_ch_done[ch] = 1'b1;
        end
        if (k == a_cyc || k == a_noop) i_abort = 1'b1;
        if (busy_poke && k == 2 && any && (a_cyc < 0 || a_cyc > 2)) begin
          i_go        = 1'b1;
          i_cfg_we    = 1'b1;
          i_cfg_ch    = 4'($urandom_range(15, 0));
          i_cfg_en    = 1'($urandom_range(1, 0));
          i_cfg_delay = 16'($urandom_range(60, 0));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    i_cfg_ch = '0; i_cfg_en = 1'b0; i_cfg_delay = '0;
    model_clear();
    for (int i = 0; i < N_CH; i++) dt[i] = 0;
    step();
    step();
    check_outs(0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Empty table: completes in cycle 1 with no ticks.
    run_seq(1'b1, -1, 1'b0, 1'b0);

    // Staggered launch 0/5/5, done ticks at 20/30/25.
    cfg(0, 1'b1, 0); cfg(1, 1'b1, 5); cfg(2, 1'b1, 5);
    dt[0] = 20; dt[1] = 30; dt[2] = 25;
    run_seq(1'b0, -1, 1'b0, 1'b0);

    // Abort at cycle 10 with ch0 running and ch3 not yet launched.
    cfg(1, 1'b0, 0); cfg(2, 1'b0, 0); cfg(0, 1'b1, 2); cfg(3, 1'b1, 100);
    dt[0] = 40; dt[3] = 300;
    run_seq(1'b0, 10, 1'b0, 1'b0);

    // Busy config write and go ignored; spurious done ticks; table unchanged afterwards.
    run_seq(1'b1, -1, 1'b1, 1'b1);
    run_seq(1'b1, -1, 1'b0, 1'b0);

    // go + abort together in idle: stays idle.
    cfg(3, 1'b0, 0);
    i_go = 1'b1; i_abort = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      idle_inputs();
      check_outs(k, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    end

    // go + config write in the same cycle: ch5 delay 3 launches in cycle 4.
    i_cfg_we = 1'b1; i_cfg_ch = 4'd5; i_cfg_en = 1'b1; i_cfg_delay = 16'd3;
    en_m[5] = 1; dly_m[5] = 3;
    run_seq(1'b1, -1, 1'b0, 1'b0);

    // Randomized tables and sequences.
    for (int it = 0; it < 6; it++) begin
      for (int w = 0; w < 4; w++)
        cfg(int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(40, 0)));
      run_seq(1'b1, (it % 2 == 0) ? 0 : -1, 1'b1, (it % 3) == 0);
      step();
    end

    // Reset while waiting for done: everything drops, table cleared.
    for (int ch = 0; ch < N_CH; ch++) cfg(ch, 1'b0, 0);
    cfg(0, 1'b1, 1);
    i_go = 1'b1;
    step();
    idle_inputs();
    step(); step(); step();
    chk("wait_active", 4, 32'(o_active), 32'h0001);
    chk("wait_busy", 4, 32'(o_busy), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs(5, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    model_clear();
    run_seq(1'b1, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
